// File: rtl/lsu_writeback_queue.sv
// LSU writeback queue: FIFO of dcache line writebacks presented to memory,
// with a cap on issued-but-unacknowledged writebacks and a sticky protocol error.
module lsu_writeback_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic                           clk,
  input  logic                           rst_i,
  input  logic                           opcode_valid_i,
  input  logic                           dcache_writeback_i,
  input  logic [ADDR_W-1:0]              addr_i,
  output logic                           accept_o,
  output logic                           mem_writeback_o,
  output logic [ADDR_W-1:0]              mem_addr_o,
  input  logic                           mem_accept_i,
  input  logic                           mem_ack_i,
  output logic [$clog2(MAX_OUT+1)-1:0]   outstanding_o,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              err_q, err_d;
  logic              req, push, pop, empty;

  // Every output is a function of registered state only, so memory-side
  // handshakes never create a combinational path back to the LSU.
  assign empty           = (cnt_q == '0);
  assign accept_o        = (cnt_q != CNT_W'(DEPTH));
  assign mem_writeback_o = !empty && (out_q != OUT_W'(MAX_OUT));
  assign mem_addr_o      = empty ? '0 : mem_q[rd_ptr_q];
  assign outstanding_o   = out_q;
  assign busy_o          = !empty || (out_q != '0);
  assign err_o           = err_q;

  assign req  = opcode_valid_i & dcache_writeback_i;
  assign push = req & accept_o;
  assign pop  = mem_writeback_o & mem_accept_i;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // An ack with nothing outstanding is dropped, unless a pop in the same
    // cycle supplies the writeback it completes.
    out_d = out_q;
    if (pop && !mem_ack_i)
      out_d = out_q + OUT_W'(1);
    else if (!pop && mem_ack_i && (out_q != '0))
      out_d = out_q - OUT_W'(1);

    err_d = err_q
          | (req & ~accept_o)
          | (mem_ack_i & ~pop & (out_q == '0));
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

  // Storage is never reset; mem_addr_o is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= addr_i;
  end

endmodule

// File: tb/tb_lsu_writeback_queue.sv
// Bench for lsu_writeback_queue: directed vector table, wrap/order sequence,
// and random traffic checked against a queue-based reference model.
module tb_lsu_writeback_queue;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 32;
  localparam int MAX_OUT = 2;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              opcode_valid_i = 1'b0;
  logic              dcache_writeback_i = 1'b0;
  logic [ADDR_W-1:0] addr_i = '0;
  logic              accept_o;
  logic              mem_writeback_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_accept_i = 1'b0;
  logic              mem_ack_i = 1'b0;
  logic [1:0]        outstanding_o;
  logic              busy_o;
  logic              err_o;

  lsu_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_i(rst_i),
    .opcode_valid_i(opcode_valid_i), .dcache_writeback_i(dcache_writeback_i),
    .addr_i(addr_i), .accept_o(accept_o),
    .mem_writeback_o(mem_writeback_o), .mem_addr_o(mem_addr_o),
    .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i),
    .outstanding_o(outstanding_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, ov, wb;
    logic [ADDR_W-1:0] a;
    logic macc, ack;
    logic eacc, ewb;
    logic [ADDR_W-1:0] eaddr;
    logic [1:0] eout;
    logic ebusy, eerr;
  } vec_t;

  vec_t tbl[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: FIFO contents, outstanding count, sticky error.
  logic [ADDR_W-1:0] mq[$];
  int                mo;
  bit                me;
  logic [ADDR_W-1:0] dut_issued[$];

  task automatic v(input logic r, ov, wb, input logic [ADDR_W-1:0] a,
                   input logic macc, ack, eacc, ewb,
                   input logic [ADDR_W-1:0] eaddr, input logic [1:0] eout,
                   input logic ebusy, eerr);
    vec_t t;
    t.r = r; t.ov = ov; t.wb = wb; t.a = a; t.macc = macc; t.ack = ack;
    t.eacc = eacc; t.ewb = ewb; t.eaddr = eaddr; t.eout = eout;
    t.ebusy = ebusy; t.eerr = eerr;
    tbl.push_back(t);
  endtask

  task automatic check(input string nm, input logic eacc, ewb,
                       input logic [ADDR_W-1:0] eaddr, input logic [1:0] eout,
                       input logic ebusy, eerr);
    vectors++;
    if (accept_o !== eacc || mem_writeback_o !== ewb || mem_addr_o !== eaddr ||
        outstanding_o !== eout || busy_o !== ebusy || err_o !== eerr) begin
      miscompares++;
      $display("FAIL %s: got acc=%b wb=%b addr=%h out=%0d busy=%b err=%b, want acc=%b wb=%b addr=%h out=%0d busy=%b err=%b",
               nm, accept_o, mem_writeback_o, mem_addr_o, outstanding_o, busy_o, err_o,
               eacc, ewb, eaddr, eout, ebusy, eerr);
    end
  endtask

  // Apply inputs on the falling edge, sample 1 time unit later.
  task automatic drive(input logic r, ov, wb, input logic [ADDR_W-1:0] a,
                       input logic macc, ack);
    @(negedge clk);
    rst_i = r; opcode_valid_i = ov; dcache_writeback_i = wb; addr_i = a;
    mem_accept_i = macc; mem_ack_i = ack;
    #1;
    if (!rst_i && mem_writeback_o && mem_accept_i) dut_issued.push_back(mem_addr_o);
  endtask

  task automatic model_check(input string nm);
    logic ewb;
    logic [ADDR_W-1:0] ea;
    if (rst_i) begin mq.delete(); mo = 0; me = 0; end
    ewb = (mq.size() != 0) && (mo < MAX_OUT);
    ea  = (mq.size() != 0) ? mq[0] : '0;
    check(nm, mq.size() < DEPTH, ewb, ea, 2'(mo), (mq.size() != 0) || (mo != 0), me);
  endtask

  // Advance the model across the coming rising edge using the held inputs.
  task automatic model_step();
    bit req, acc, pop;
    if (rst_i) return;
    req = opcode_valid_i && dcache_writeback_i;
    acc = mq.size() < DEPTH;
    pop = (mq.size() != 0) && (mo < MAX_OUT) && mem_accept_i;
    if (req && !acc) me = 1;
    if (mem_ack_i && !pop && mo == 0) me = 1;
    if (pop && !mem_ack_i) mo++;
    else if (!pop && mem_ack_i && mo > 0) mo--;
    if (pop) void'(mq.pop_front());
    if (req && acc) mq.push_back(addr_i);
  endtask

  task automatic cyc(input string nm, input logic r, ov, wb,
                     input logic [ADDR_W-1:0] a, input logic macc, ack);
    drive(r, ov, wb, a, macc, ack);
    model_check(nm);
    model_step();
  endtask

  initial begin
    logic [ADDR_W-1:0] wrap_addrs[$];
    logic [ADDR_W-1:0] p100, p600;

    mq.delete(); mo = 0; me = 0;

    // reset, then unguarded writebacks never enqueue
    v(1,0,0,0,0,0, 1,0,0,0,0,0);
    for (int i = 0; i < 10; i++) v(0,0,1,32'hDEAD,1,0, 1,0,0,0,0,0);
    // MAX_OUT throttling and ack release
    v(0,1,1,32'h100,0,0, 1,0,0,0,0,0);
    v(0,1,1,32'h140,0,0, 1,1,32'h100,0,1,0);
    v(0,1,1,32'h180,0,0, 1,1,32'h100,0,1,0);
    v(0,0,0,0,1,0,       1,1,32'h100,0,1,0);
    v(0,0,0,0,1,0,       1,1,32'h140,1,1,0);
    v(0,0,0,0,1,0,       1,0,32'h180,2,1,0);
    v(0,0,0,0,1,1,       1,0,32'h180,2,1,0);
    v(0,0,0,0,0,0,       1,1,32'h180,1,1,0);
    v(0,0,0,0,1,0,       1,1,32'h180,1,1,0);
    v(0,0,0,0,0,1,       1,0,0,2,1,0);
    v(0,0,0,0,0,1,       1,0,0,1,1,0);
    v(0,0,0,0,0,0,       1,0,0,0,0,0);
    // stray ack
    v(0,0,0,0,0,1,       1,0,0,0,0,0);
    v(0,0,0,0,0,0,       1,0,0,0,0,1);
    v(1,0,0,0,0,0,       1,0,0,0,0,0);
    v(0,0,0,0,0,0,       1,0,0,0,0,0);
    // fill to DEPTH, fifth attempt dropped
    v(0,1,1,32'h100,0,0, 1,0,0,0,0,0);
    v(0,1,1,32'h140,0,0, 1,1,32'h100,0,1,0);
    v(0,1,1,32'h180,0,0, 1,1,32'h100,0,1,0);
    v(0,1,1,32'h1C0,0,0, 1,1,32'h100,0,1,0);
    v(0,1,1,32'h200,0,0, 0,1,32'h100,0,1,0);
    v(0,0,0,0,0,0,       0,1,32'h100,0,1,1);
    v(1,0,0,0,0,0,       1,0,0,0,0,0);
    v(0,0,0,0,0,0,       1,0,0,0,0,0);
    // full queue: head accepted while push attempted -> push refused
    v(0,1,1,32'h100,0,0, 1,0,0,0,0,0);
    v(0,1,1,32'h140,0,0, 1,1,32'h100,0,1,0);
    v(0,1,1,32'h180,0,0, 1,1,32'h100,0,1,0);
    v(0,1,1,32'h1C0,0,0, 1,1,32'h100,0,1,0);
    v(0,1,1,32'h300,1,0, 0,1,32'h100,0,1,0);
    v(0,0,0,0,0,0,       1,1,32'h140,1,1,1);
    // same-cycle pop and ack with nothing outstanding
    v(1,0,0,0,0,0,       1,0,0,0,0,0);
    v(0,0,0,0,0,0,       1,0,0,0,0,0);
    v(0,1,1,32'h500,0,0, 1,0,0,0,0,0);
    v(0,0,0,0,1,1,       1,1,32'h500,0,1,0);
    v(0,0,0,0,0,0,       1,0,0,0,0,0);
    // reset mid-operation with 3 queued, 1 outstanding
    v(0,1,1,32'h600,0,0, 1,0,0,0,0,0);
    v(0,1,1,32'h640,0,0, 1,1,32'h600,0,1,0);
    v(0,1,1,32'h680,1,0, 1,1,32'h600,0,1,0);
    v(0,1,1,32'h6C0,0,0, 1,1,32'h640,1,1,0);
    v(1,0,0,0,0,0,       1,0,0,0,0,0);
    v(0,0,0,0,1,0,       1,0,0,0,0,0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].ov, tbl[i].wb, tbl[i].a, tbl[i].macc, tbl[i].ack);
      check($sformatf("row%0d", i), tbl[i].eacc, tbl[i].ewb, tbl[i].eaddr,
            tbl[i].eout, tbl[i].ebusy, tbl[i].eerr);
      if (rst_i) begin mq.delete(); mo = 0; me = 0; end
      model_step();
    end

    // Two laps of the pointers: 8 writebacks must issue in push order.
    cyc("wrap_rst", 1, 0, 0, 0, 0, 0);
    dut_issued.delete();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      wrap_addrs.push_back(32'h7000 + i * 32'h40);
      cyc($sformatf("wrap%0d", i), 0, 1, 1, 32'h7000 + i * 32'h40, 1, mo > 0);
    end
    for (int i = 0; i < 12; i++)
      cyc($sformatf("drain%0d", i), 0, 0, 0, 0, 1, mo > 0);
    vectors++;
    if (dut_issued.size() != wrap_addrs.size()) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d issued, want %0d", dut_issued.size(), wrap_addrs.size());
    end else begin
      foreach (wrap_addrs[i]) begin
        vectors++;
        if (dut_issued[i] !== wrap_addrs[i]) begin
          miscompares++;
          $display("FAIL wrap_order%0d: got %h want %h", i, dut_issued[i], wrap_addrs[i]);
        end
      end
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic r, ov, wb, macc, ack;
      r    = ($urandom_range(0, 199) == 0);
      ov   = ($urandom_range(0, 3) != 0);
      wb   = $urandom_range(0, 1) == 1;
      macc = $urandom_range(0, 1) == 1;
      ack  = (mo > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 63) == 0);
      cyc($sformatf("rand%0d", i), r, ov, wb, $urandom, macc, ack);
    end

    p100 = 32'h100; p600 = 32'h600;
    if (p100 == p600) $display("note: address constants collide");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
